// File: rtl/cla_seq_add16.sv
// 16-bit add/subtract built from one 4-bit carry-lookahead slice reused over
// four nibbles (LSB first), with a valid/ready handshake on both sides.
module cla_seq_add16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] sum,
    output logic        cout,
    output logic        ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic        r_carry;
    logic [1:0]  r_idx;
    logic [15:0] r_sum;
    logic        r_cout;
    logic        r_ovf;

    logic [3:0]  w_na;
    logic [3:0]  w_nb;
    logic [3:0]  w_g;
    logic [3:0]  w_p;
    logic [3:0]  w_s;
    logic [4:0]  w_c;

    // Operand nibble selected by the current index feeds the shared slice.
    assign w_na   = r_a[{r_idx, 2'b00} +: 4];
    assign w_nb   = r_b[{r_idx, 2'b00} +: 4];
    assign w_c[0] = r_carry;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slice
            assign w_g[gi]      = w_na[gi] & w_nb[gi];
            assign w_p[gi]      = w_na[gi] ^ w_nb[gi];
            assign w_c[gi + 1]  = w_g[gi] | (w_p[gi] & w_c[gi]);
            assign w_s[gi]      = w_p[gi] ^ w_c[gi];
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_next = RUN;
            RUN:     if (r_idx == 2'd3) w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= 16'h0000;
            r_b     <= 16'h0000;
            r_carry <= 1'b0;
            r_idx   <= 2'd0;
            r_sum   <= 16'h0000;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction is A + ~B + 1: invert B and seed the carry.
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_carry <= sub;
                        r_idx   <= 2'd0;
                    end
                end
                RUN: begin
                    r_sum[{r_idx, 2'b00} +: 4] <= w_s;
                    r_carry <= w_c[4];
                    r_idx   <= r_idx + 2'd1;
                    if (r_idx == 2'd3) begin
                        r_cout <= w_c[4];
                        r_ovf  <= w_c[3] ^ w_c[4];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule

// File: doc/cla_seq_add16.md
CLA_SEQ_ADD16 -- requirements
Module: cla_seq_add16

Interface
REQ-001 The block SHALL have no parameters; the word width is fixed at 16 bits, processed as four 4-bit nibbles.
REQ-002 clk  input  1  Sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  Reset, synchronous and active-high.
REQ-004 in_valid  input  1  Requester presents an operation.
REQ-005 in_ready  output  1  Block can accept an operation.
REQ-006 a  input  16  Operand A.
REQ-007 b  input  16  Operand B.
REQ-008 sub  input  1  0 selects A+B; 1 selects A-B.
REQ-009 out_valid  output  1  Result available.
REQ-010 out_ready  input  1  Consumer accepts the result.
REQ-011 sum  output  16  Result word.
REQ-012 cout  output  1  Carry out of bit 15 (for subtract, 1 means no borrow).
REQ-013 ovf  output  1  Two's-complement signed overflow.

Function
REQ-014 The block SHALL time-multiplex one internal 4-bit carry-lookahead slice over four nibbles, LSB nibble first, one nibble per cycle.
REQ-015 The slice SHALL compute per bit g=a&b and p=a^b, carries c[i+1]=g[i]|(p[i]&c[i]), and sum bit s[i]=p[i]^c[i].
REQ-016 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-017 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-018 Accept: on an edge with IDLE&in_valid, the block SHALL latch a, latch b (or ~b when sub=1), set the carry register to sub, clear the nibble index to 0, and go to RUN.
REQ-019 RUN: each edge SHALL write nibble[idx] of sum, load the slice carry-out into the carry register, and increment idx.
REQ-020 RUN: the edge that writes idx=3 SHALL also latch cout and latch ovf (carry into bit 15 XOR carry out of bit 15), then go to DONE.
REQ-021 Latency: out_valid SHALL rise exactly 4 cycles after the accepting edge.
REQ-022 DONE: sum, cout and ovf SHALL be held stable until the edge with out_ready=1, after which the FSM SHALL go to IDLE.
REQ-023 There SHALL be no overlap: in_valid SHALL be ignored in RUN and DONE, and a new accept can occur no earlier than the cycle after the output handshake.
REQ-024 a, b and sub SHALL be sampled only at accept; later changes SHALL not affect the result in flight.
REQ-025 in_valid and out_ready high in IDLE SHALL have no effect beyond the accept.
REQ-026 sum/cout/ovf SHALL retain their last values after the output handshake until overwritten by the next operation.
REQ-027 The 16-bit result SHALL wrap modulo 2^16; bit 16 appears only on cout.

Reset
REQ-028 On an edge with rst=1, the FSM SHALL go to IDLE, idx SHALL go to 0, the carry register SHALL go to 0, and sum, cout and ovf SHALL go to 0.
REQ-029 rst asserted in RUN or DONE SHALL abort the operation with no result delivered; the cycle after the reset edge SHALL show in_ready=1 and out_valid=0.
REQ-030 rst SHALL take priority over any simultaneous in_valid or out_ready.

Verification
REQ-031 Add: a=0x1234, b=0x4321, sub=0 -> out_valid 4 cycles after accept, with sum=0x5555, cout=0, ovf=0.
REQ-032 Carry ripple: a=0xFFFF, b=0x0001, sub=0 -> sum=0x0000, cout=1, ovf=0.
REQ-033 Signed overflow: a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, cout=0, ovf=1.
REQ-034 Subtract with borrow: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0, ovf=0.
REQ-035 Backpressure: hold out_ready=0 for 3 cycles in DONE while toggling in_valid, a and b -> sum, cout and ovf stay unchanged, in_ready stays 0, and IDLE follows the out_ready edge.
REQ-036 Mid-operation reset: assert rst after 2 RUN edges -> next cycle shows in_ready=1, out_valid=0, sum=0x0000; a following add of 0x0001+0x0001 returns 0x0002.
